// File: rtl/ins_loader_pkg.sv
// ============================================================================
// ins_loader_pkg
// ----------------------------------------------------------------------------
// Shared constants for the instruction-memory loader:
//   - default field widths for the instruction format (opcode, a/b/r fields,
//     instruction memory address)
//   - helper functions that derive the packed word width and the number of
//     stream bytes carried per instruction
//   - FSM state encodings, kept as plain localparam constants so older tools
//     and existing dumps that decode the 3-bit state keep working
// ============================================================================
package ins_loader_pkg;

   // Default widths of the instruction format
   localparam int INS_ADDR_WIDTH_DEF = 10;
   localparam int ADDR_WIDTH_DEF     = 10;
   localparam int OPCODE_WIDTH_DEF   = 3;

   // Packed instruction width: opcode plus the three data address fields
   function automatic int ins_width(input int opcode_w, input int addr_w);
      return opcode_w + 3 * addr_w;
   endfunction

   // Stream bytes needed to carry one instruction word (rounded up)
   function automatic int bytes_per_word(input int word_w);
      return (word_w + 7) / 8;
   endfunction

   // FSM state encodings
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_HDR0  = 3'd1;
   localparam logic [2:0] ST_HDR1  = 3'd2;
   localparam logic [2:0] ST_BYTES = 3'd3;
   localparam logic [2:0] ST_WRITE = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/ins_loader.sv
// ============================================================================
// ins_loader
// ----------------------------------------------------------------------------
// Writer side of the instruction memory. A program arrives as a byte stream
// (valid/ready): a 16-bit little-endian instruction count N, followed by N
// instruction words of NB bytes each, every word little-endian. Each word is
// packed and written into instruction memory at consecutive addresses from 0.
// The core is held in reset (core_rstn low) until the whole program is in.
//
// Ports
//   clk, rst    clock and asynchronous active-high reset
//   load_start  1-cycle pulse starting a new load (honoured in IDLE / DONE)
//   s_data      stream byte
//   s_valid     stream byte valid
//   s_ready     loader can accept a byte (HDR0, HDR1, BYTES only)
//   ins_we      instruction memory write strobe, one cycle per word
//   ins_waddr   instruction memory write address
//   ins_wdata   packed word: opcode in the LSBs, then r, b, a (a at MSBs)
//   prog_len    number of instructions written by the last load
//   load_done   program complete; held until the next load_start
//   len_err     header count exceeded memory depth (sticky for the load)
//   core_rstn   active-low core reset, released only in DONE
// ============================================================================
module ins_loader
   import ins_loader_pkg::*;
#(
   parameter int INS_ADDR_WIDTH = INS_ADDR_WIDTH_DEF,
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int OPCODE_WIDTH   = OPCODE_WIDTH_DEF
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  load_start,
   input  logic [7:0]                            s_data,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   output logic                                  ins_we,
   output logic [INS_ADDR_WIDTH-1:0]             ins_waddr,
   output logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0]  ins_wdata,
   output logic [INS_ADDR_WIDTH:0]               prog_len,
   output logic                                  load_done,
   output logic                                  len_err,
   output logic                                  core_rstn
);

   localparam int INS_W = ins_width(OPCODE_WIDTH, ADDR_WIDTH);
   localparam int NB    = bytes_per_word(INS_W);
   // Only the first NB-1 bytes of a word need storage; the final byte is
   // taken straight from the stream when the word is committed.
   localparam int SR_W  = (NB - 1) * 8;
   localparam int BC_W  = $clog2(NB + 1);
   localparam int EFF_W = INS_ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << INS_ADDR_WIDTH;

   logic [2:0]                state_q, state_d;
   logic [7:0]                hdr_lo_q, hdr_lo_d;
   logic [EFF_W-1:0]          eff_cnt_q, eff_cnt_d;
   logic [EFF_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic [BC_W-1:0]           byte_cnt_q, byte_cnt_d;
   logic [SR_W-1:0]           word_q, word_d;
   logic                      ins_we_q, ins_we_d;
   logic [INS_ADDR_WIDTH-1:0] ins_waddr_q, ins_waddr_d;
   logic [INS_W-1:0]          ins_wdata_q, ins_wdata_d;
   logic [EFF_W-1:0]          prog_len_q, prog_len_d;
   logic                      len_err_q, len_err_d;

   logic                      accept;
   logic [15:0]               hdr_n;
   logic                      last_word;

   // Handshake and status outputs depend only on the current state, so the
   // loader never offers ready in a cycle where it cannot store the byte.
   always_comb begin
      s_ready   = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                  (state_q == ST_BYTES);
      load_done = (state_q == ST_DONE);
      core_rstn = (state_q == ST_DONE);
   end

   always_comb begin
      accept    = s_valid && s_ready;
      hdr_n     = {s_data, hdr_lo_q};
      last_word = (wr_ptr_q == (eff_cnt_q - EFF_W'(1)));
   end

   assign ins_we    = ins_we_q;
   assign ins_waddr = ins_waddr_q;
   assign ins_wdata = ins_wdata_q;
   assign prog_len  = prog_len_q;
   assign len_err   = len_err_q;

   // Next-state and datapath logic. The write strobe and the write address
   // and data are registered on the edge that accepts the last byte of a
   // word, so they appear together during the WRITE cycle and the address
   // and data hold afterwards.
   always_comb begin
      state_d     = state_q;
      hdr_lo_d    = hdr_lo_q;
      eff_cnt_d   = eff_cnt_q;
      wr_ptr_d    = wr_ptr_q;
      byte_cnt_d  = byte_cnt_q;
      word_d      = word_q;
      ins_we_d    = 1'b0;
      ins_waddr_d = ins_waddr_q;
      ins_wdata_d = ins_wdata_q;
      prog_len_d  = prog_len_q;
      len_err_d   = len_err_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (load_start) begin
               state_d    = ST_HDR0;
               wr_ptr_d   = '0;
               byte_cnt_d = '0;
               prog_len_d = '0;
               len_err_d  = 1'b0;
            end
         end

         ST_HDR0: begin
            if (accept) begin
               hdr_lo_d = s_data;
               state_d  = ST_HDR1;
            end
         end

         ST_HDR1: begin
            if (accept) begin
               // Counts beyond the memory depth are clamped; the surplus
               // stream bytes are simply left unconsumed.
               if ({16'd0, hdr_n} > 32'(DEPTH)) begin
                  len_err_d = 1'b1;
                  eff_cnt_d = EFF_W'(DEPTH);
               end else begin
                  eff_cnt_d = EFF_W'(hdr_n);
               end
               byte_cnt_d = '0;
               state_d    = (hdr_n == 16'd0) ? ST_DONE : ST_BYTES;
            end
         end

         ST_BYTES: begin
            if (accept) begin
               // Bytes enter at the top and shift down, so the first byte
               // of the word ends up in the least significant position.
               word_d = SR_W'({s_data, word_q} >> 8);
               if (byte_cnt_q == BC_W'(NB - 1)) begin
                  byte_cnt_d  = '0;
                  ins_we_d    = 1'b1;
                  ins_waddr_d = wr_ptr_q[INS_ADDR_WIDTH-1:0];
                  // Bits of the final byte above the word width drop off here
                  ins_wdata_d = INS_W'({s_data, word_q});
                  state_d     = ST_WRITE;
               end else begin
                  byte_cnt_d = byte_cnt_q + BC_W'(1);
               end
            end
         end

         ST_WRITE: begin
            prog_len_d = wr_ptr_q + EFF_W'(1);
            if (last_word) begin
               state_d = ST_DONE;
            end else begin
               wr_ptr_d = wr_ptr_q + EFF_W'(1);
               state_d  = ST_BYTES;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any partial byte or word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hdr_lo_q    <= '0;
         eff_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         byte_cnt_q  <= '0;
         word_q      <= '0;
         ins_we_q    <= 1'b0;
         ins_waddr_q <= '0;
         ins_wdata_q <= '0;
         prog_len_q  <= '0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_lo_q    <= hdr_lo_d;
         eff_cnt_q   <= eff_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         byte_cnt_q  <= byte_cnt_d;
         word_q      <= word_d;
         ins_we_q    <= ins_we_d;
         ins_waddr_q <= ins_waddr_d;
         ins_wdata_q <= ins_wdata_d;
         prog_len_q  <= prog_len_d;
         len_err_q   <= len_err_d;
      end
   end

endmodule
